// File: rtl/trig_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trig_frame_pkg
// Purpose  : Shared definitions for the trigger tx framer: frame markers,
//            header/trailer field positions, framer state encoding and the
//            16-bit checksum fold.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package trig_frame_pkg;

    // Frame markers
    localparam logic [7:0] HDR_MARK = 8'hA5;
    localparam logic [3:0] TRL_MARK = 4'hE;

    // Header field LSB positions: [31:24] mark, [23:16] channel, [15:8] seq
    localparam int HDR_MARK_LSB = 24;
    localparam int HDR_CHAN_LSB = 16;
    localparam int HDR_SEQ_LSB  = 8;

    // Trailer fields: [31:28] mark, [27] trunc, [26:16] count, [15:0] xor16
    localparam int TRL_MARK_LSB  = 28;
    localparam int TRL_TRUNC_BIT = 27;
    localparam int TRL_CNT_LSB   = 16;
    localparam int TRL_CNT_W     = 11;
    localparam int TRL_XOR_LSB   = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PAY   = 3'd1,
        TRL   = 3'd2,
        TRL_D = 3'd3,
        DROP  = 3'd4
    } frame_state_t;

    // Folds one payload word into its 16-bit checksum contribution.
    function automatic logic [15:0] xor16_fold(input logic [31:0] w);
        return w[31:16] ^ w[15:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/trig_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : trig_sync_fifo
// Purpose  : Single-clock circular buffer, non-FWFT, registered read data.
// Ports    : clk, rst_n (async active-low)
//            wr_en/wr_data  - write, ignored when full (no bypass)
//            rd_en/rd_data  - pop, ignored when empty; rd_data updates on the
//                             popping edge and otherwise holds
//            empty/full/count - occupancy status (post-edge)
// Revision : 1.0 - initial release
// ============================================================================
module trig_sync_fifo #(
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [31:0]              wr_data,
    input  logic                     rd_en,
    output logic [31:0]              rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_rd_data;

    logic w_full;
    logic w_empty;
    logic w_do_wr;
    logic w_do_rd;

    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);
    // A full buffer refuses writes even if the same edge frees a slot.
    assign w_do_wr = wr_en && !w_full;
    assign w_do_rd = rd_en && !w_empty;

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr];
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_rd_data;
    assign empty   = w_empty;
    assign full    = w_full;
    assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/trig_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : trig_tx_framer
// Purpose  : Wraps trigger events into header / payload / trailer frames with
//            sequence number and xor16 checksum, buffered for the Aurora tx
//            wrapper's FIFO-style read port.
// Ports    : user_clk, rst_n (async active-low)
//            ev_valid_i/ev_data_i/ev_last_i/ev_ready_o - event word input
//            fifo_read_i/fifo_data_o/fifo_empty_o      - tx read port
//            seq_o   - sequence number of next frame
//            trunc_o - one-cycle pulse when a frame hits MAX_PAYLOAD
//            level_o - buffer occupancy
// Revision : 1.0 - initial release
// ============================================================================
module trig_tx_framer
    import trig_frame_pkg::*;
#(
    parameter int         DEPTH       = 512,
    parameter int         MAX_PAYLOAD = 255,
    parameter logic [7:0] CHAN_ID     = 8'h00
) (
    input  logic                     user_clk,
    input  logic                     rst_n,
    input  logic                     ev_valid_i,
    input  logic [31:0]              ev_data_i,
    input  logic                     ev_last_i,
    output logic                     ev_ready_o,
    input  logic                     fifo_read_i,
    output logic [31:0]              fifo_data_o,
    output logic                     fifo_empty_o,
    output logic [7:0]               seq_o,
    output logic                     trunc_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int LW = $clog2(DEPTH) + 1;
    // Header needs room for itself plus at least one more word.
    localparam logic [LW-1:0]        C_ROOM2_LIM = LW'(DEPTH - 1);
    localparam logic [TRL_CNT_W-1:0] C_MAX_PAY   = TRL_CNT_W'(MAX_PAYLOAD);

    frame_state_t         r_state;
    frame_state_t         w_next_state;
    logic [7:0]           r_seq;
    logic [TRL_CNT_W-1:0] r_cnt;
    logic [15:0]          r_xor;
    logic                 r_trunc_pulse;

    logic        w_full;
    logic [LW-1:0] w_level;
    logic        w_wr_en;
    logic [31:0] w_wr_data;
    logic        w_ready;
    logic        w_hdr_start;
    logic        w_accept_pay;
    logic        w_trunc_set;
    logic        w_trl_done;
    logic [31:0] w_hdr_word;
    logic [31:0] w_trl_word;

    always_comb begin
        w_hdr_word = '0;
        w_hdr_word[HDR_MARK_LSB +: 8] = HDR_MARK;
        w_hdr_word[HDR_CHAN_LSB +: 8] = CHAN_ID;
        w_hdr_word[HDR_SEQ_LSB  +: 8] = r_seq;

        w_trl_word = '0;
        w_trl_word[TRL_MARK_LSB +: 4]         = TRL_MARK;
        w_trl_word[TRL_TRUNC_BIT]             = (r_state == TRL_D);
        w_trl_word[TRL_CNT_LSB +: TRL_CNT_W]  = r_cnt;
        w_trl_word[TRL_XOR_LSB +: 16]         = r_xor;
    end

    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        w_wr_data    = ev_data_i;
        w_ready      = 1'b0;
        w_hdr_start  = 1'b0;
        w_accept_pay = 1'b0;
        w_trunc_set  = 1'b0;
        w_trl_done   = 1'b0;
        case (r_state)
            IDLE: begin
                // Event word stays pending upstream while the header goes in.
                if (ev_valid_i && (w_level < C_ROOM2_LIM)) begin
                    w_wr_en      = 1'b1;
                    w_wr_data    = w_hdr_word;
                    w_hdr_start  = 1'b1;
                    w_next_state = PAY;
                end
            end
            PAY: begin
                w_ready = !w_full;
                if (ev_valid_i && !w_full) begin
                    w_wr_en      = 1'b1;
                    w_accept_pay = 1'b1;
                    if (ev_last_i) begin
                        w_next_state = TRL;
                    end else if ((r_cnt + 1'b1) == C_MAX_PAY) begin
                        w_trunc_set  = 1'b1;
                        w_next_state = TRL_D;
                    end
                end
            end
            TRL, TRL_D: begin
                if (!w_full) begin
                    w_wr_en      = 1'b1;
                    w_wr_data    = w_trl_word;
                    w_trl_done   = 1'b1;
                    w_next_state = (r_state == TRL_D) ? DROP : IDLE;
                end
            end
            DROP: begin
                w_ready = 1'b1;
                if (ev_valid_i && ev_last_i) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge user_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_seq         <= '0;
            r_cnt         <= '0;
            r_xor         <= '0;
            r_trunc_pulse <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_trunc_pulse <= w_trunc_set;
            if (w_trl_done) begin
                r_seq <= r_seq + 1'b1;
            end
            if (w_hdr_start) begin
                r_cnt <= '0;
                r_xor <= '0;
            end else if (w_accept_pay) begin
                r_cnt <= r_cnt + 1'b1;
                r_xor <= r_xor ^ xor16_fold(ev_data_i);
            end
        end
    end

    trig_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (user_clk),
        .rst_n   (rst_n),
        .wr_en   (w_wr_en),
        .wr_data (w_wr_data),
        .rd_en   (fifo_read_i),
        .rd_data (fifo_data_o),
        .empty   (fifo_empty_o),
        .full    (w_full),
        .count   (w_level)
    );

    assign ev_ready_o = w_ready;
    assign seq_o      = r_seq;
    assign trunc_o    = r_trunc_pulse;
    assign level_o    = w_level;

endmodule
`default_nettype wire

// File: doc/trig_tx_framer.md
Name: trig_tx_framer

Overview:
- Frames trigger event words from the trigger-consolidation logic into sequence-numbered, checksummed packets.
- Buffers the framed words and presents them on the FIFO-style read port consumed by the Aurora `tx` wrapper: data, empty and read.
- Sits directly upstream of `tx`, on the `tx` `user_clk` domain.

Parameters:
- DEPTH, 512, buffer depth in 32-bit words; power of 2, ≥ 8.
- MAX_PAYLOAD, 255, maximum payload words per frame; 1..2047.
- CHAN_ID, 8'h00, channel identifier written into the header.

Ports:
- user_clk  in  1  sole clock; the Aurora tx user clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ev_valid_i  in  1  event word valid.
- ev_data_i  in  32  event word.
- ev_last_i  in  1  marks the final word of an event, qualified by ev_valid_i.
- ev_ready_o  out  1  framer accepts the word this cycle.
- fifo_read_i  in  1  read strobe from tx.
- fifo_data_o  out  32  registered read data.
- fifo_empty_o  out  1  buffer holds no unread words.
- seq_o  out  8  sequence number of the next frame.
- trunc_o  out  1  one-cycle pulse when a frame is truncated.
- level_o  out  $clog2(DEPTH)+1  buffer occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - Buffer pointers and count cleared; state set to IDLE; seq cleared.
  - Outputs: fifo_data_o=0, fifo_empty_o=1, ev_ready_o=0, trunc_o=0, level_o=0, seq_o=0.
  - A reset mid-frame discards the partial frame and all buffered words.
- Word formats:
  - Header: [31:24]=8'hA5, [23:16]=CHAN_ID, [15:8]=seq, [7:0]=0.
  - Trailer: [31:28]=4'hE, [27]=trunc, [26:16]=payload count, [15:0]=xor16.
  - xor16 = XOR over payload words of (w[31:16]^w[15:0]); the accumulator is cleared at each header.
- Buffer:
  - Circular, DEPTH words; full when count==DEPTH.
  - A write is blocked when full; there is no bypass, even with a same-cycle read.
- Read side (non-FWFT):
  - fifo_read_i with fifo_empty_o=0 pops one word; fifo_data_o updates on the next edge.
  - fifo_empty_o goes 1 on the same edge that pops the last stored word; that popped word is then on fifo_data_o.
  - fifo_read_i while empty is ignored; fifo_data_o holds.
  - Simultaneous write and read: count unchanged.
- State machine:
  - IDLE:
    - ev_ready_o=0.
    - If ev_valid_i and free ≥ 2: write header, clear cnt and xor -> PAY.
    - The event word is held upstream, not consumed.
  - PAY:
    - ev_ready_o = !full.
    - On accept: write word, cnt+1, fold into xor.
    - If ev_last_i is accepted -> TRL.
    - Else if cnt reaches MAX_PAYLOAD: set trunc, pulse trunc_o -> TRL_D.
  - TRL:
    - ev_ready_o=0.
    - When !full: write trailer with trunc=0, seq+1 (wraps 255->0) -> IDLE.
  - TRL_D:
    - Same as TRL but trunc=1, then -> DROP.
  - DROP:
    - ev_ready_o=1; incoming words are discarded until ev_last_i is accepted -> IDLE.
- Payload count and xor cover only words actually written.
- level_o equals count and reflects the post-edge value.
- Latency: an accepted word reaches fifo_data_o no earlier than 2 cycles later, via one write edge and one read edge.

Decomposition:
- Package trig_frame_pkg:
  - HDR_MARK=8'hA5, TRL_MARK=4'hE.
  - Field bit positions for header and trailer.
  - State enum: IDLE, PAY, TRL, TRL_D, DROP.
  - xor16 fold function.
- Sub-module trig_sync_fifo:
  - Circular buffer with registered read data, empty, full and count.
  - Parameterized by DEPTH.
  - Instantiated once; the framer FSM lives in the top.

Test Plan:
- Single 3-word event 32'h11112222, 32'h33334444, 32'h55556666 (last on 3rd), then read continuously:
  - Read sequence: 32'hA5000000, the three words, 32'hE0037777.
  - fifo_empty_o=1 after the 5th pop; seq_o=1.
- 300-word event with MAX_PAYLOAD=255:
  - trunc_o pulses once.
  - Trailer bit27=1, count=255.
  - Remaining 45 words are dropped with ev_ready_o=1.
  - The next event's header carries seq=1.
- DEPTH=8, no reads, 10-word event:
  - Header plus 7 payload words written; level_o=8, ev_ready_o=0.
  - One read lets exactly one more word in.
- 256 back-to-back 1-word events with reads enabled:
  - Header seq runs 0..255; the 257th frame's header has seq=0 (wrap).
- Read on empty at reset release: fifo_data_o stays 0, fifo_empty_o stays 1.
- rst_n low mid-PAY after 2 payload words:
  - Outputs return to reset values immediately (async).
  - After release the next event produces a header with seq=0 and no remnants.
